// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch resolution sequencer
package branch_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} br_state_e;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_RESET = 2'b01;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition evaluator
// Ports: a, b operands; funct3 branch type; taken direction; illegal for funct3 010/011.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);
  logic lt;
  always_comb begin
    illegal = !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
    lt      = funct3[1] ? (a < b) : ($signed(a) < $signed(b));
    // bit 0 inverts the base relation: bne/bge/bgeu are complements of beq/blt/bltu
    taken   = illegal ? 1'b0 : ((funct3[2] ? lt : (a == b)) ^ funct3[0]);
  end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch resolution sequencer with redirect and multi-cycle flush
// Ports: req_* one branch per valid/ready handshake; lookup_pc/lookup_taken fetch-time
// prediction; resolve_* one-cycle result pulse; redirect_valid/redirect_pc corrected fetch
// PC; flush kills younger instructions; busy when not idle.
// Macro BRANCH_CTRL_BHT_EN compiles in a 2-bit saturating-counter branch history table;
// without it lookup_taken is 0 and req_pred_taken is treated as 0.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [2:0]      req_funct3,
  input  logic            req_pred_taken,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            resolve_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            busy
);
  br_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q, rpc_q;
  logic [2:0] f3_q;
  logic [3:0] cnt_q;
  logic taken, illegal, mispredict;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a(rs1_q),
    .b(rs2_q),
    .funct3(f3_q),
    .taken(taken),
    .illegal(illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      pc_q  <= req_pc;
      imm_q <= req_imm;
      rs1_q <= req_rs1;
      rs2_q <= req_rs2;
      f3_q  <= req_funct3;
    end
    if (state_q == EVAL) rpc_q <= taken ? pc_q + imm_q : pc_q + XLEN'(4);
    // REDIRECT is the first flush cycle, so FLUSH itself lasts FLUSH_CYCLES-1 cycles
    if (state_q == REDIRECT) cnt_q <= 4'(FLUSH_CYCLES - 1);
    else if (state_q == FLUSH) cnt_q <= cnt_q - 4'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = req_valid ? EVAL : IDLE;
      EVAL:     state_d = mispredict ? REDIRECT : IDLE;
      REDIRECT: state_d = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
      FLUSH:    state_d = (cnt_q == 4'd1) ? IDLE : FLUSH;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = state_q == IDLE;
    busy            = state_q != IDLE;
    resolve_valid   = state_q == EVAL;
    resolve_taken   = resolve_valid & taken;
    resolve_illegal = resolve_valid & illegal;
    redirect_valid  = state_q == REDIRECT;
    redirect_pc     = redirect_valid ? rpc_q : '0;
    flush           = state_q == REDIRECT || state_q == FLUSH;
  end

`ifdef BRANCH_CTRL_BHT_EN
  localparam int IW = $clog2(BHT_ENTRIES);
  bht_ctr_t bht_q [BHT_ENTRIES];
  logic pred_q;
  logic [IW-1:0] upd_idx, lk_idx;
  logic unused_lookup;
  assign upd_idx       = pc_q[IW+1:2];
  assign lk_idx        = lookup_pc[IW+1:2];
  assign lookup_taken  = bht_q[lk_idx][1];
  assign mispredict    = taken != pred_q;
  assign unused_lookup = ^{lookup_pc[XLEN-1:IW+2], lookup_pc[1:0]};
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) pred_q <= req_pred_taken;
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
    end else if (state_q == EVAL && !illegal) begin
      bht_q[upd_idx] <= taken ? (bht_q[upd_idx] == 2'b11 ? 2'b11 : bht_q[upd_idx] + 2'b01)
                              : (bht_q[upd_idx] == 2'b00 ? 2'b00 : bht_q[upd_idx] - 2'b01);
    end
  end
`else
  logic unused_lookup;
  assign lookup_taken  = 1'b0;
  assign mispredict    = taken;
  assign unused_lookup = ^{lookup_pc, req_pred_taken};
`endif
endmodule
